// File: rtl/blackjack_pkg.sv
// Shared blackjack types: deck size, card index type, deck FSM states and a
// rank helper for the hand controllers.
package blackjack_pkg;

  localparam int DECK_SIZE = 52;

  typedef logic [5:0] cardIndex_t;

  typedef enum logic [2:0] {
    S_INIT,
    S_PICK,
    S_SWAP,
    S_READY,
    S_GRANT
  } deckState_t;

  // Card index is suit*13 + rank-1, so the rank is recovered modulo 13.
  function automatic logic [3:0] rankOf(input cardIndex_t idx);
    cardIndex_t r;
    r = (idx % 6'd13) + 6'd1;
    return r[3:0];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, shifting right.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [15:0] o_state
);

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge i_clk) begin
    if (i_reset) o_state <= SEED;
    else         o_state <= {1'b0, o_state[15:1]} ^ (o_state[0] ? 16'hB400 : 16'h0000);
  end

endmodule

// File: rtl/deck_arbiter.sv
// Owns the 52-card deck: fills and Fisher-Yates shuffles it in place, then
// deals one card per grant to the player or dealer with round-robin arbitration.
module deck_arbiter
  import blackjack_pkg::*;
#(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          DECK_SIZE = blackjack_pkg::DECK_SIZE
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_playerReq,
  input  logic       i_dealerReq,
  input  logic       i_shuffleReq,
  output logic       o_playerGrant,
  output logic       o_dealerGrant,
  output logic [5:0] o_card,
  output logic       o_ready,
  output logic       o_shuffling,
  output logic [5:0] o_cardsRemaining
);

  localparam cardIndex_t FULL    = cardIndex_t'(DECK_SIZE);
  localparam cardIndex_t TOP_IDX = cardIndex_t'(DECK_SIZE - 1);

  deckState_t state, next_state;
  cardIndex_t deck [DECK_SIZE];
  cardIndex_t ptr, idx_i, idx_j, mask, cand;
  logic       last_grant, grant_dealer;
  logic       accept, any_req, both_req, win_dealer, restart, take;
  logic [15:0] lfsr;
  logic       unused_lfsr;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_state (lfsr)
  );
  assign unused_lfsr = ^lfsr[15:6];

  // Smallest all-ones mask covering idx_i keeps rejection below 50%.
  always_comb begin
    if      (idx_i >= 6'd32) mask = 6'd63;
    else if (idx_i >= 6'd16) mask = 6'd31;
    else if (idx_i >= 6'd8)  mask = 6'd15;
    else if (idx_i >= 6'd4)  mask = 6'd7;
    else if (idx_i >= 6'd2)  mask = 6'd3;
    else                     mask = 6'd1;
  end

  assign cand       = lfsr[5:0] & mask;
  assign accept     = (cand <= idx_i);
  assign any_req    = i_playerReq | i_dealerReq;
  assign both_req   = i_playerReq & i_dealerReq;
  assign win_dealer = i_dealerReq & (~i_playerReq | ~last_grant);

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_INIT;
    else         state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state    = state;
    restart       = 1'b0;
    take          = 1'b0;
    o_playerGrant = 1'b0;
    o_dealerGrant = 1'b0;
    o_ready       = 1'b0;
    o_shuffling   = 1'b0;
    case (state)
      S_INIT: begin
        o_shuffling = 1'b1;
        next_state  = S_PICK;
      end
      S_PICK: begin
        o_shuffling = 1'b1;
        if (accept) next_state = S_SWAP;
      end
      S_SWAP: begin
        o_shuffling = 1'b1;
        next_state  = (idx_i == 6'd1) ? S_READY : S_PICK;
      end
      S_READY: begin
        o_ready = 1'b1;
        if (i_shuffleReq || (any_req && ptr == FULL)) begin
          restart    = 1'b1;
          next_state = S_PICK;
        end else if (any_req) begin
          take       = 1'b1;
          next_state = S_GRANT;
        end
      end
      S_GRANT: begin
        o_playerGrant = ~grant_dealer;
        o_dealerGrant = grant_dealer;
        next_state    = S_READY;
      end
      default: next_state = S_INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr          <= '0;
      idx_i        <= TOP_IDX;
      idx_j        <= '0;
      last_grant   <= 1'b0;
      grant_dealer <= 1'b0;
      o_card       <= '0;
    end else begin
      case (state)
        S_INIT: begin
          ptr   <= '0;
          idx_i <= TOP_IDX;
        end
        S_PICK: if (accept) idx_j <= cand;
        S_SWAP: if (idx_i != 6'd1) idx_i <= idx_i - 6'd1;
        S_READY: begin
          if (restart) begin
            ptr   <= '0;
            idx_i <= TOP_IDX;
          end else if (take) begin
            o_card       <= deck[ptr];
            ptr          <= ptr + 6'd1;
            grant_dealer <= win_dealer;
            if (both_req) last_grant <= win_dealer;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the deck array has no reset; S_INIT always refills it before use,
  // and leaving it out keeps reset fan-out off 312 storage flops.
  always_ff @(posedge i_clk) begin
    if (state == S_INIT) begin
      for (int k = 0; k < DECK_SIZE; k++) deck[k] <= cardIndex_t'(k);
    end else if (state == S_SWAP) begin
      deck[idx_i] <= deck[idx_j];
      deck[idx_j] <= deck[idx_i];
    end
  end

  assign o_cardsRemaining = FULL - ptr;

endmodule

// File: tb/tb_deck_arbiter.sv
// Self-checking bench for deck_arbiter: Fisher-Yates reference model driven by
// its own LFSR sequence, directed scenarios plus a randomized request phase.
module tb_deck_arbiter;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, preq, dreq, sreq;
  logic       pg, dg, rdy, shuf;
  logic [5:0] card, rem;

  deck_arbiter #(.SEED(SEED), .DECK_SIZE(52)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_playerReq      (preq),
    .i_dealerReq      (dreq),
    .i_shuffleReq     (sreq),
    .o_playerGrant    (pg),
    .o_dealerGrant    (dg),
    .o_card           (card),
    .o_ready          (rdy),
    .o_shuffling      (shuf),
    .o_cardsRemaining (rem)
  );

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [15:0] lfsr_m;
  int          mdeck [52];
  int          mptr;
  bit          mlast;
  int          last_card;
  int          dut_cards[$];
  int          grant_log[$];
  int          first_order[52];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int mask_for(input int i);
    int m;
    m = 0;
    while (m < i) m = m * 2 + 1;
    return m;
  endfunction

  // One clock; the model LFSR tracks the value the DUT holds in the new cycle.
  task automatic tick();
    @(posedge clk);
    lfsr_m = rst ? SEED : lfsr_next(lfsr_m);
    #1;
  endtask

  task automatic check_busy(input string tag);
    check(tag, {shuf, rdy, pg, dg, rem}, {1'b1, 1'b0, 1'b0, 1'b0, 6'd52});
  endtask

  // Walks the shuffle cycle by cycle from INIT (refill) or the first PICK.
  task automatic run_shuffle(input bit refill, input int abort_i, output bit aborted);
    int cand, tmp;
    aborted = 1'b0;
    if (refill) begin
      for (int k = 0; k < 52; k++) mdeck[k] = k;
      mlast     = 1'b0;
      last_card = 0;
      check_busy("init");
      tick();
    end
    mptr = 0;
    for (int i = 51; i >= 1; i--) begin
      if (i == abort_i) begin
        rst = 1'b1;
        tick();
        check_busy("reset_in_pick");
        check("reset_in_pick_card", card, 6'd0);
        aborted = 1'b1;
        return;
      end
      do begin
        cand = int'(lfsr_m[5:0]) & mask_for(i);
        check_busy("pick");
        tick();
      end while (cand > i);
      tmp         = mdeck[i];
      mdeck[i]    = mdeck[cand];
      mdeck[cand] = tmp;
      check_busy("swap");
      tick();
    end
    check("ready_after_shuffle", {rdy, shuf, rem}, {1'b1, 1'b0, 6'd52});
  endtask

  // Called in a READY cycle: applies inputs and checks the DUT's response.
  task automatic serve(input bit p, input bit d, input bit s, input bit hold, input bit sg);
    bit ab;
    int w;
    preq = p;
    dreq = d;
    sreq = s;
    if (s || ((p || d) && mptr == 52)) begin
      tick();
      sreq = 1'b0;
      run_shuffle(1'b0, -1, ab);
    end else if (p || d) begin
      w = (p && d) ? int'(!mlast) : int'(d);
      if (p && d) mlast = w[0];
      tick();
      check("grant", {pg, dg, rdy, shuf}, {w == 0, w == 1, 1'b0, 1'b0});
      check("card", card, mdeck[mptr]);
      dut_cards.push_back(int'(card));
      grant_log.push_back(w);
      last_card = mdeck[mptr];
      mptr++;
      check("remaining", rem, 52 - mptr);
      if (!hold) begin
        preq = 1'b0;
        dreq = 1'b0;
      end
      sreq = sg;
      tick();
      sreq = 1'b0;
      check("back_ready", {rdy, pg, dg, card}, {1'b1, 1'b0, 1'b0, 6'(last_card)});
    end else begin
      tick();
      check("idle", {rdy, pg, dg}, 3'b100);
    end
  endtask

  initial begin
    bit          ab;
    logic [63:0] seen;
    int          dups, diff;

    rst = 1'b1; preq = 1'b0; dreq = 1'b0; sreq = 1'b0;
    lfsr_m = SEED;
    repeat (3) tick();
    check("reset_outputs", {pg, dg, card, rdy, shuf, rem}, {1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd52});
    rst = 1'b0;
    run_shuffle(1'b1, -1, ab);

    // Player-only: a full deck, checked as a permutation.
    dut_cards.delete();
    repeat (52) serve(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    seen = '0;
    dups = 0;
    foreach (dut_cards[k]) begin
      if (seen[dut_cards[k]]) dups++;
      seen[dut_cards[k]] = 1'b1;
    end
    check("perm_cover", seen, 64'h000F_FFFF_FFFF_FFFF);
    check("perm_dups", dups, 0);
    check("exhausted_remaining", rem, 6'd0);
    foreach (first_order[k]) first_order[k] = dut_cards[k];

    // Dealer request on an empty deck triggers a reshuffle, then is served.
    serve(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    serve(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("after_reshuffle_remaining", rem, 6'd51);

    // Shuffle beats a simultaneous request; shuffle pulse during GRANT ignored.
    serve(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    serve(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    serve(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("no_reshuffle_from_grant", rem, 6'd50);

    // Randomized traffic against the model.
    repeat (200) serve(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Both requests held high from reset: strict alternation starting with dealer.
    rst = 1'b1; preq = 1'b1; dreq = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    run_shuffle(1'b1, -1, ab);
    grant_log.delete();
    repeat (12) serve(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    diff = 0;
    foreach (grant_log[k]) if (grant_log[k] != ((k % 2 == 0) ? 1 : 0)) diff++;
    check("alternation", diff, 0);

    // Reset mid-shuffle at i = 30, then the same seed must give the same order.
    preq = 1'b0; dreq = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_shuffle(1'b1, 30, ab);
    rst = 1'b0;
    run_shuffle(1'b1, -1, ab);
    dut_cards.delete();
    repeat (52) serve(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    diff = 0;
    foreach (first_order[k]) if (dut_cards[k] != first_order[k]) diff++;
    check("reproducible_order", diff, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/deck_arbiter.md
# deck_arbiter

Owns the 52-card deck and shares it between the player and dealer hand controllers. After reset it fills the deck and performs an in-place Fisher-Yates shuffle driven by a free-running LFSR. It then serves one-card draw requests from the two requesters with round-robin arbitration, and reshuffles on command or on exhaustion. It sits between the game FSM and both hand controllers, replacing direct deck access.

## Interface
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- DECK_SIZE, 52, number of cards; fixed at 52 for this design.
- i_clk  in  1  clock; all state changes on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_playerReq  in  1  player requests one card (level).
- i_dealerReq  in  1  dealer requests one card (level).
- i_shuffleReq  in  1  game FSM requests reshuffle (pulse).
- o_playerGrant  out  1  one-cycle pulse; o_card is valid for the player.
- o_dealerGrant  out  1  one-cycle pulse; o_card is valid for the dealer.
- o_card  out  6  deck index 0..51, encoded as suit*13 + rank-1; held until the next grant.
- o_ready  out  1  in S_READY and able to accept requests.
- o_shuffling  out  1  in S_INIT, S_PICK or S_SWAP.
- o_cardsRemaining  out  6  DECK_SIZE − ptr.

## Operation
- Storage: 52×6 flop array `deck`, 6-bit dealt pointer `ptr`, 6-bit shuffle index `i`, 1-bit `lastGrant` (0 = player).
- The LFSR is 16-bit Galois, x^16+x^14+x^13+x^11+1, loaded with SEED on reset. It advances every cycle in every state, so the timing of user input adds entropy.
- State S_INIT, one cycle: deck[k] = k for all k; ptr = 0; i = 51; go to S_PICK.
- State S_PICK:
  - cand = LFSR[5:0] & mask(i), where mask = smallest 2^n − 1 ≥ i.
  - If cand ≤ i: latch j = cand and go to S_SWAP.
  - Otherwise stay in S_PICK (rejection). Acceptance probability is ≥ 50% per cycle.
- State S_SWAP: swap deck[i] and deck[j] in one cycle.
  - If i == 1, go to S_READY.
  - Otherwise decrement i and go to S_PICK.
- State S_READY, priority order:
  1. If i_shuffleReq: set ptr = 0, i = 51, go to S_PICK. No deck re-fill; the shuffle is in place.
  2. Else if any request and ptr == 52 (exhausted): go to S_PICK as in (1). No grant is issued; the request stays pending and is served after the shuffle.
  3. Else if any request: pick the winner, then o_card ← deck[ptr], ptr ← ptr + 1, go to S_GRANT.
     - If only one requester, it wins.
     - If both, the one not equal to lastGrant wins, and lastGrant updates to the winner.
- State S_GRANT: assert the winner's grant for exactly this cycle, then return to S_READY. Requests are not sampled in S_GRANT.
- i_shuffleReq is ignored outside S_READY and is not queued.
- At most one grant is asserted per cycle; both grants are never high together.

## Timing
- Reset values: grants 0, o_card 0, o_ready 0, o_shuffling 1, o_cardsRemaining 52, lastGrant 0, state S_INIT.
- Reset taken in any state, including mid-shuffle or in S_GRANT, returns to S_INIT on the next edge. A grant in flight is dropped.
- Shuffle duration = 1 + Σ(PICK cycles) + 51 SWAP cycles. The minimum is 103 cycles from reset release to o_ready.
- Draw latency: request high in a READY cycle N gives the grant and valid o_card in cycle N+1. Back in READY at N+2.
- A requester must deassert in the cycle it sees its grant. A request still high at N+2 is served again, giving a maximum throughput of one card per 2 cycles.
- o_ready is registered from the state and equals (state == S_READY).
- o_cardsRemaining reads 0 after the 52nd grant and returns to 52 on the first S_PICK cycle of a reshuffle.

## Structure
- Shared package `blackjack_pkg` holds:
  - DECK_SIZE
  - the cardIndex_t (6-bit) typedef
  - the deckState_t enum (S_INIT, S_PICK, S_SWAP, S_READY, S_GRANT)
  - a function rankOf(idx) = idx % 13 + 1, used by hand controllers.
- One sub-module `lfsr16` (i_clk, i_reset, SEED → 16-bit state), instanced once.
- Arbiter, FSM and deck array live in deck_arbiter.

## Test plan
- Reset, then no requests → o_ready rises ≥ 103 and < 2000 cycles after reset release; o_cardsRemaining = 52; no grants while shuffling.
- Player-only requests, 52 times → 52 player grants, each one cycle after the request; o_card values are a permutation of 0..51; o_cardsRemaining ends at 0.
- Player and dealer requests held high together from reset → grants alternate dealer, player, dealer, …, one grant every 2 cycles, never both in the same cycle.
- After 52 cards, hold i_dealerReq → o_shuffling = 1 with no grant; after the reshuffle, the first dealer grant arrives with o_cardsRemaining = 51.
- i_shuffleReq and i_playerReq in the same READY cycle → reshuffle starts and there is no grant that cycle; i_shuffleReq pulsed during S_GRANT has no effect.
- i_reset asserted during S_PICK with i = 30 → next cycle state S_INIT, o_ready = 0, o_cardsRemaining = 52; the same SEED reproduces the identical card order.
